// File: rtl/timer_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_bus_pkg
// Description : Shared types and constants for the machine-timer bus
//               responder: responder FSM state encoding, register offsets,
//               CTRL bit positions and a byte-lane merge helper.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_bus_pkg;

    // Responder FSM states (explicit 2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT  = 2'd1,
        ST_RESP = 2'd2
    } bus_state_e;

    // Word offsets (addr[4:2]) of the register map
    localparam logic [2:0] c_OFF_MTIME_LO    = 3'd0;
    localparam logic [2:0] c_OFF_MTIME_HI    = 3'd1;
    localparam logic [2:0] c_OFF_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] c_OFF_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] c_OFF_CTRL        = 3'd4;
    localparam logic [2:0] c_OFF_PRESCALE    = 3'd5;

    // CTRL register bit positions
    localparam int unsigned c_CTRL_EN = 0;

    // Replace each byte of old_val whose enable is set with the matching
    // byte of new_val.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Offsets 6 and 7 have no register behind them.
    function automatic logic is_mapped(input logic [2:0] off);
        return (off <= c_OFF_PRESCALE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_bus_fsm.sv
`default_nettype none
// ============================================================================
// Module      : timer_bus_fsm
// Description : Generic req/gnt/rvalid responder. Captures one access in
//               IDLE, grants it for one cycle, then returns a one-cycle
//               response. Register-file agnostic: the owner supplies read
//               data and an error flag for the captured offset and receives
//               a one-cycle write-commit strobe at the edge that ends GNT.
//
// Ports       : clk_i, rst_ni        clock, async active-low reset
//               i_req/i_we/i_be/     bus request side (held stable until
//               i_off/i_wdata        grant)
//               o_gnt/o_rvalid/      bus response side, all flop-driven
//               o_rdata/o_err
//               o_wr_commit          write strobe, high during GNT of a write
//               o_acc_off/o_acc_be/  captured access attributes
//               o_acc_wdata
//               i_rd_data/i_acc_err  register-file read value / error for
//                                    the captured offset
// Revision    : 1.0 - initial release
// ============================================================================
module timer_bus_fsm
    import timer_bus_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [3:0]  i_be,
    input  logic [2:0]  i_off,
    input  logic [31:0] i_wdata,
    output logic        o_gnt,
    output logic        o_rvalid,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic        o_wr_commit,
    output logic [2:0]  o_acc_off,
    output logic [3:0]  o_acc_be,
    output logic [31:0] o_acc_wdata,
    input  logic [31:0] i_rd_data,
    input  logic        i_acc_err
);

    bus_state_e  r_state;
    bus_state_e  w_state_nxt;

    logic        r_we;
    logic [3:0]  r_be;
    logic [2:0]  r_off;
    logic [31:0] r_wdata;

    logic        r_gnt;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        r_err;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. req_i is only looked at in IDLE, so a request
    // held through RESP is picked up on the following IDLE cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_req) begin
                    w_state_nxt = ST_GNT;
                end
            end
            ST_GNT:  w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Access capture and registered bus outputs. gnt/rvalid are the
    // registered images of "entering GNT" / "entering RESP", so no
    // combinational path from req_i reaches the outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we     <= 1'b0;
            r_be     <= 4'd0;
            r_off    <= 3'd0;
            r_wdata  <= 32'd0;
            r_gnt    <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && i_req) begin
                r_we    <= i_we;
                r_be    <= i_be;
                r_off   <= i_off;
                r_wdata <= i_wdata;
            end

            r_gnt    <= (w_state_nxt == ST_GNT);
            r_rvalid <= (r_state == ST_GNT);

            // Read data is sampled at the edge that ends GNT; writes and
            // errored accesses return zero. Outside RESP the data is zero.
            if (r_state == ST_GNT) begin
                r_rdata <= (!r_we && !i_acc_err) ? i_rd_data : 32'd0;
                r_err   <= i_acc_err;
            end else begin
                r_rdata <= 32'd0;
                r_err   <= 1'b0;
            end
        end
    end

    assign o_gnt       = r_gnt;
    assign o_rvalid    = r_rvalid;
    assign o_rdata     = r_rdata;
    assign o_err       = r_err;
    assign o_wr_commit = (r_state == ST_GNT) && r_we;
    assign o_acc_off   = r_off;
    assign o_acc_be    = r_be;
    assign o_acc_wdata = r_wdata;

endmodule
`default_nettype wire

// File: rtl/timer_bus_resp.sv
`default_nettype none
// ============================================================================
// Module      : timer_bus_resp
// Description : Memory-mapped machine timer on the data-side req/gnt/rvalid
//               bus. 64-bit mtime with a programmable prescaler, 64-bit
//               mtimecmp and a registered level interrupt.
//
// Ports       : clk_i, rst_ni        clock, async active-low reset
//               req_i, we_i, be_i,   bus request (addr_i[4:2] selects the
//               addr_i, wdata_i      register, other address bits ignored)
//               gnt_o, rvalid_o,     bus response
//               rdata_o, err_o
//               timer_irq_o          level interrupt: enable & mtime>=mtimecmp
//
// Register map (word offset):
//               0 MTIME_LO  1 MTIME_HI  2 MTIMECMP_LO  3 MTIMECMP_HI
//               4 CTRL (bit0 enable)   5 PRESCALE   6,7 unmapped (error)
// Revision    : 1.0 - initial release
// ============================================================================
module timer_bus_resp
    import timer_bus_pkg::*;
#(
    parameter int unsigned PRESCALE_WIDTH = 16,
    parameter logic [63:0] MTIMECMP_RST   = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        timer_irq_o
);

    // ------------------------------------------------------------------
    // Bus responder
    // ------------------------------------------------------------------
    logic        w_wr_commit;
    logic [2:0]  w_acc_off;
    logic [3:0]  w_acc_be;
    logic [31:0] w_acc_wdata;
    logic [31:0] w_rd_data;
    logic        w_acc_err;

    // Only addr_i[4:2] carries information inside this block's window.
    logic w_unused_addr;
    assign w_unused_addr = ^{addr_i[31:5], addr_i[1:0]};

    timer_bus_fsm u_fsm (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .i_req       (req_i),
        .i_we        (we_i),
        .i_be        (be_i),
        .i_off       (addr_i[4:2]),
        .i_wdata     (wdata_i),
        .o_gnt       (gnt_o),
        .o_rvalid    (rvalid_o),
        .o_rdata     (rdata_o),
        .o_err       (err_o),
        .o_wr_commit (w_wr_commit),
        .o_acc_off   (w_acc_off),
        .o_acc_be    (w_acc_be),
        .o_acc_wdata (w_acc_wdata),
        .i_rd_data   (w_rd_data),
        .i_acc_err   (w_acc_err)
    );

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [63:0]               r_mtime;
    logic [63:0]               r_mtimecmp;
    logic                      r_en;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [PRESCALE_WIDTH-1:0] r_cnt;
    logic                      r_irq;

    logic                      w_wr_mtime_lo;
    logic                      w_wr_mtime_hi;
    logic                      w_wr_cmp_lo;
    logic                      w_wr_cmp_hi;
    logic                      w_wr_ctrl;
    logic                      w_wr_prescale;

    assign w_wr_mtime_lo = w_wr_commit && (w_acc_off == c_OFF_MTIME_LO);
    assign w_wr_mtime_hi = w_wr_commit && (w_acc_off == c_OFF_MTIME_HI);
    assign w_wr_cmp_lo   = w_wr_commit && (w_acc_off == c_OFF_MTIMECMP_LO);
    assign w_wr_cmp_hi   = w_wr_commit && (w_acc_off == c_OFF_MTIMECMP_HI);
    assign w_wr_ctrl     = w_wr_commit && (w_acc_off == c_OFF_CTRL);
    assign w_wr_prescale = w_wr_commit && (w_acc_off == c_OFF_PRESCALE);

    // Prescale register viewed as a 32-bit bus word.
    logic [31:0] w_prescale_rd;
    logic [31:0] w_prescale_merge;

    assign w_prescale_rd    = 32'(r_prescale);
    assign w_prescale_merge = merge_bytes(w_prescale_rd, w_acc_wdata, w_acc_be);

    // Bits above the prescaler width are write-ignored.
    generate
        if (PRESCALE_WIDTH < 32) begin : g_prescale_pad
            logic w_unused_prescale_hi;
            assign w_unused_prescale_hi = ^w_prescale_merge[31:PRESCALE_WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Timer tick: the counter runs 0..prescale, and the cycle it sits at
    // prescale is the cycle mtime advances. prescale=0 ticks every cycle.
    // ------------------------------------------------------------------
    logic        w_tick;
    logic [63:0] w_mtime_nxt;

    assign w_tick = r_en && (r_cnt == r_prescale);

    // A software write to either half overrides the increment for that
    // cycle; the untouched half keeps its current value.
    always_comb begin
        w_mtime_nxt = r_mtime + {63'd0, w_tick};
        if (w_wr_mtime_lo) begin
            w_mtime_nxt = {r_mtime[63:32], merge_bytes(r_mtime[31:0], w_acc_wdata, w_acc_be)};
        end else if (w_wr_mtime_hi) begin
            w_mtime_nxt = {merge_bytes(r_mtime[63:32], w_acc_wdata, w_acc_be), r_mtime[31:0]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mtime    <= 64'd0;
            r_mtimecmp <= MTIMECMP_RST;
            r_en       <= 1'b0;
            r_prescale <= '0;
            r_cnt      <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_mtime <= w_mtime_nxt;

            if (w_wr_cmp_lo) begin
                r_mtimecmp[31:0] <= merge_bytes(r_mtimecmp[31:0], w_acc_wdata, w_acc_be);
            end
            if (w_wr_cmp_hi) begin
                r_mtimecmp[63:32] <= merge_bytes(r_mtimecmp[63:32], w_acc_wdata, w_acc_be);
            end

            if (w_wr_ctrl && w_acc_be[0]) begin
                r_en <= w_acc_wdata[c_CTRL_EN];
            end

            if (w_wr_prescale) begin
                r_prescale <= w_prescale_merge[PRESCALE_WIDTH-1:0];
            end

            // Prescale writes restart the count so the new period starts
            // cleanly; otherwise the counter only moves while enabled.
            if (w_wr_prescale) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                r_cnt <= '0;
            end else if (r_en) begin
                r_cnt <= r_cnt + 1'b1;
            end

            r_irq <= r_en && (r_mtime >= r_mtimecmp);
        end
    end

    assign timer_irq_o = r_irq;

    // ------------------------------------------------------------------
    // Read mux for the captured offset
    // ------------------------------------------------------------------
    assign w_acc_err = !is_mapped(w_acc_off);

    always_comb begin
        w_rd_data = 32'd0;
        case (w_acc_off)
            c_OFF_MTIME_LO:    w_rd_data = r_mtime[31:0];
            c_OFF_MTIME_HI:    w_rd_data = r_mtime[63:32];
            c_OFF_MTIMECMP_LO: w_rd_data = r_mtimecmp[31:0];
            c_OFF_MTIMECMP_HI: w_rd_data = r_mtimecmp[63:32];
            c_OFF_CTRL:        w_rd_data[c_CTRL_EN] = r_en;
            c_OFF_PRESCALE:    w_rd_data = w_prescale_rd;
            default:           w_rd_data = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_timer_bus_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_bus_resp
// Description : Self-checking bench for timer_bus_resp. Directed scenarios
//               followed by randomized accesses, all compared against a
//               behavioural model of the timer kept in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_timer_bus_resp;

    logic        clk_i   = 1'b0;
    logic        rst_ni  = 1'b0;
    logic        req_i   = 1'b0;
    logic        we_i    = 1'b0;
    logic [3:0]  be_i    = 4'd0;
    logic [31:0] addr_i  = 32'd0;
    logic [31:0] wdata_i = 32'd0;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        timer_irq_o;

    always #5 clk_i = ~clk_i;

    timer_bus_resp dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .timer_irq_o (timer_irq_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: mtime advances once per (prescale+1) enabled
    // cycles; m_phase counts enabled cycles since the last advance.
    // ------------------------------------------------------------------
    logic [63:0] m_time;
    logic [63:0] m_cmp;
    logic [31:0] m_pre;
    int unsigned m_phase;
    bit          m_en;
    bit          m_irq;

    function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = n[8*k +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_time  = 64'd0;
        m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
        m_pre   = 32'd0;
        m_phase = 0;
        m_en    = 1'b0;
        m_irq   = 1'b0;
    endtask

    // One clock edge, optionally committing a write.
    task automatic model_edge(input bit wr, input int off, input logic [3:0] be,
                              input logic [31:0] d);
        bit          tick;
        logic [63:0] t_n;
        tick  = m_en && (m_phase == m_pre);
        m_irq = m_en && (m_time >= m_cmp);
        t_n   = m_time + (tick ? 64'd1 : 64'd0);
        if (m_en) m_phase = tick ? 0 : m_phase + 1;
        if (wr) begin
            case (off)
                0: t_n = {m_time[63:32], lane_merge(m_time[31:0], d, be)};
                1: t_n = {lane_merge(m_time[63:32], d, be), m_time[31:0]};
                2: m_cmp[31:0]  = lane_merge(m_cmp[31:0], d, be);
                3: m_cmp[63:32] = lane_merge(m_cmp[63:32], d, be);
                4: if (be[0]) m_en = d[0];
                5: begin
                    m_pre   = lane_merge(m_pre, d, be) & 32'h0000_FFFF;
                    m_phase = 0;
                end
                default: ;
            endcase
        end
        m_time = t_n;
    endtask

    function automatic logic [31:0] model_read(input int off);
        case (off)
            0: return m_time[31:0];
            1: return m_time[63:32];
            2: return m_cmp[31:0];
            3: return m_cmp[63:32];
            4: return {31'd0, m_en};
            5: return m_pre;
            default: return 32'd0;
        endcase
    endfunction

    // Advance one clock (from negedge to negedge) and check the interrupt.
    task automatic cyc(input bit wr, input int off, input logic [3:0] be, input logic [31:0] d);
        @(posedge clk_i);
        if (!rst_ni) model_reset();
        else         model_edge(wr, off, be, d);
        @(negedge clk_i);
        check("irq", timer_irq_o, m_irq);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(1'b0, 0, 4'd0, 32'd0);
            check("idle_outs", {gnt_o, rvalid_o, err_o, rdata_o}, 35'd0);
        end
    endtask

    // Full bus access. junk_resp drives a spurious request during RESP,
    // which must be ignored.
    task automatic access(input bit we, input int off, input logic [3:0] be,
                          input logic [31:0] d, input bit junk_resp,
                          output logic [31:0] rd, output logic er);
        logic [31:0] exp_rd;
        bit          exp_err;
        req_i   = 1'b1;
        we_i    = we;
        be_i    = be;
        addr_i  = ($urandom & 32'hFFFF_FFE3) | (32'(off) << 2);
        wdata_i = d;
        cyc(1'b0, 0, 4'd0, 32'd0);
        check("gnt_cycle", {gnt_o, rvalid_o}, 2'b10);
        // Bus lines are free after grant; scramble them.
        req_i   = 1'b0;
        we_i    = 1'($urandom);
        be_i    = 4'($urandom);
        addr_i  = $urandom;
        wdata_i = $urandom;
        exp_err = (off > 5);
        exp_rd  = (we || exp_err) ? 32'd0 : model_read(off);
        cyc(we, off, be, d);
        check("rvalid_cycle", {gnt_o, rvalid_o}, 2'b01);
        check("rdata", rdata_o, exp_rd);
        check("err", err_o, exp_err);
        rd = rdata_o;
        er = err_o;
        if (junk_resp) begin
            req_i = 1'b1;
            we_i  = 1'b1;
        end
        cyc(1'b0, 0, 4'd0, 32'd0);
        req_i = 1'b0;
        check("resp_end", {gnt_o, rvalid_o, err_o, rdata_o}, 35'd0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        model_reset();
        cyc(1'b0, 0, 4'd0, 32'd0);
        rst_ni = 1'b1;
    endtask

    logic [31:0] rd, rd2;
    logic        er;

    initial begin
        model_reset();
        @(negedge clk_i);
        cyc(1'b0, 0, 4'd0, 32'd0);
        check("reset_outs", {gnt_o, rvalid_o, err_o, timer_irq_o, rdata_o}, 36'd0);
        rst_ni = 1'b1;

        // Reset values
        access(1'b0, 0, 4'hF, 32'd0, 1'b0, rd, er);
        check("rst_mtime_lo", rd, 32'd0);
        access(1'b0, 3, 4'hF, 32'd0, 1'b0, rd, er);
        check("rst_cmp_hi", rd, 32'hFFFF_FFFF);

        // Prescale 3: about one tick per 4 cycles
        access(1'b1, 5, 4'hF, 32'd3, 1'b0, rd, er);
        access(1'b1, 4, 4'hF, 32'd1, 1'b0, rd, er);
        idle(40);
        access(1'b0, 0, 4'hF, 32'd0, 1'b0, rd, er);
        check("p3_range", (rd >= 32'd9) && (rd <= 32'd11), 1'b1);

        // Prescale 0: one tick per cycle; reads are 3 cycles apart
        access(1'b1, 5, 4'hF, 32'd0, 1'b0, rd, er);
        access(1'b0, 0, 4'hF, 32'd0, 1'b0, rd, er);
        access(1'b0, 0, 4'hF, 32'd0, 1'b0, rd2, er);
        check("p0_delta", rd2 - rd, 32'd3);

        // Carry from LO into HI
        access(1'b1, 1, 4'hF, 32'd0, 1'b0, rd, er);
        access(1'b1, 0, 4'hF, 32'hFFFF_FFFE, 1'b0, rd, er);
        access(1'b0, 1, 4'hF, 32'd0, 1'b0, rd, er);
        check("carry_hi", rd, 32'd1);

        // Full 64-bit wrap
        access(1'b1, 4, 4'hF, 32'd0, 1'b0, rd, er);
        access(1'b1, 0, 4'hF, 32'hFFFF_FFFF, 1'b0, rd, er);
        access(1'b1, 1, 4'hF, 32'hFFFF_FFFF, 1'b0, rd, er);
        access(1'b1, 4, 4'hF, 32'd1, 1'b0, rd, er);
        access(1'b0, 1, 4'hF, 32'd0, 1'b0, rd, er);
        check("wrap_hi", rd, 32'd0);

        // Interrupt at mtime reaching 20, then cleared by raising mtimecmp
        access(1'b1, 4, 4'hF, 32'd0, 1'b0, rd, er);
        access(1'b1, 0, 4'hF, 32'd0, 1'b0, rd, er);
        access(1'b1, 1, 4'hF, 32'd0, 1'b0, rd, er);
        access(1'b1, 3, 4'hF, 32'd0, 1'b0, rd, er);
        access(1'b1, 2, 4'hF, 32'd20, 1'b0, rd, er);
        access(1'b1, 4, 4'hF, 32'd1, 1'b0, rd, er);
        idle(25);
        check("irq_high", timer_irq_o, 1'b1);
        access(1'b1, 2, 4'hF, 32'hFFFF_FFFF, 1'b0, rd, er);
        idle(2);
        check("irq_low", timer_irq_o, 1'b0);

        // Byte-lane write and unmapped offsets
        do_reset();
        access(1'b1, 2, 4'b0010, 32'h0000_AB00, 1'b0, rd, er);
        access(1'b0, 2, 4'hF, 32'd0, 1'b0, rd, er);
        check("be_merge", rd, 32'hFFFF_ABFF);
        access(1'b1, 6, 4'hF, 32'hDEAD_BEEF, 1'b0, rd, er);
        check("unmapped_wr_err", er, 1'b1);
        access(1'b0, 6, 4'hF, 32'd0, 1'b0, rd, er);
        check("unmapped_rd", {er, rd}, {1'b1, 32'd0});
        access(1'b0, 7, 4'hF, 32'd0, 1'b0, rd, er);
        for (int o = 0; o < 6; o++) access(1'b0, o, 4'hF, 32'd0, 1'b0, rd, er);

        // Reset during GNT of a write: nothing commits, no response
        req_i = 1'b1; we_i = 1'b1; be_i = 4'hF; addr_i = 32'h8; wdata_i = 32'h1234_5678;
        cyc(1'b0, 0, 4'd0, 32'd0);
        check("midrst_gnt", gnt_o, 1'b1);
        req_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        check("midrst_async", {gnt_o, rvalid_o, err_o, rdata_o}, 35'd0);
        cyc(1'b0, 0, 4'd0, 32'd0);
        check("midrst_norsp", {gnt_o, rvalid_o}, 2'b00);
        rst_ni = 1'b1;
        access(1'b0, 2, 4'hF, 32'd0, 1'b0, rd, er);
        check("midrst_cmp_lo", rd, 32'hFFFF_FFFF);

        // Randomized accesses
        for (int it = 0; it < 120; it++) begin
            int          off;
            logic [31:0] d;
            off = int'($urandom_range(0, 7));
            d   = $urandom;
            if (off == 1 || off == 3) d = $urandom_range(0, 1);
            if (off == 5)             d = $urandom_range(0, 4);
            access(1'($urandom), off, 4'($urandom), d, 1'($urandom), rd, er);
            idle(int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
